// File: rtl/sha256_msg_padder.sv
// Pads a big-endian 32-bit word stream into 512-bit SHA-256 blocks (0x80 marker, zero fill, bit length).
// Define SHA256_PAD_ERR_CHK_EN to add a sticky err output for malformed beats and length overflow.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last,
    output logic [511:0] blk_data
`ifdef SHA256_PAD_ERR_CHK_EN
    ,
    output logic         err
`endif
);

    typedef enum logic {ACCUM, OUT} state_t;

    state_t            state_reg, state_next;
    logic [0:63][7:0]  buf_reg, buf_next;
    logic [3:0]        idx_reg, idx_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic              first_reg, first_next;
    logic              extra_reg, extra_next;
    logic              mark_reg, mark_next;
    logic              bfirst_reg, bfirst_next;
    logic              blast_reg, blast_next;

    logic              in_fire, blk_fire;
    logic [2:0]        n_eff;
    logic [0:3][7:0]   beat_bytes;
    logic [LEN_W-1:0]  cnt_add;
    logic [6:0]        pos;
    logic [63:0]       len_new, len_cur;

    assign in_fire = in_valid & in_ready;
    assign blk_fire = blk_valid & blk_ready;

    // Only the last beat may be short; anything above 4 is clamped.
    assign n_eff = (in_last && in_nbytes <= 3'd4) ? in_nbytes : 3'd4;
    assign pos = {1'b0, idx_reg, 2'b00} + {4'b0000, n_eff};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_beat
            assign beat_bytes[gi] = (3'(gi) < n_eff) ? in_data[31-8*gi -: 8] : 8'h00;
        end
    endgenerate

`ifdef SHA256_PAD_ERR_CHK_EN
    logic cnt_carry;
    logic err_reg, err_next;
    assign {cnt_carry, cnt_add} = {1'b0, cnt_reg} + (LEN_W+1)'({n_eff, 3'b000});
    assign err_next = err_reg | (in_fire & ((!in_last && in_nbytes != 3'd4) ||
                                            (in_nbytes > 3'd4) || cnt_carry));
    assign err = err_reg;
`else
    assign cnt_add = cnt_reg + LEN_W'({n_eff, 3'b000});
`endif

    assign len_new = 64'(cnt_add);
    assign len_cur = 64'(cnt_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ACCUM;
            buf_reg    <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            first_reg  <= 1'b1;
            extra_reg  <= 1'b0;
            mark_reg   <= 1'b0;
            bfirst_reg <= 1'b0;
            blast_reg  <= 1'b0;
`ifdef SHA256_PAD_ERR_CHK_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            buf_reg    <= buf_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            first_reg  <= first_next;
            extra_reg  <= extra_next;
            mark_reg   <= mark_next;
            bfirst_reg <= bfirst_next;
            blast_reg  <= blast_next;
`ifdef SHA256_PAD_ERR_CHK_EN
            err_reg    <= err_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        buf_next    = buf_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        first_next  = first_reg;
        extra_next  = extra_reg;
        mark_next   = mark_reg;
        bfirst_next = bfirst_reg;
        blast_next  = blast_reg;
        case (state_reg)
            ACCUM: begin
                if (in_fire) begin
                    for (int k = 0; k < 4; k++) begin
                        buf_next[{idx_reg, 2'(k)}] = beat_bytes[k];
                    end
                    cnt_next = cnt_add;
                    if (!in_last) begin
                        idx_next = idx_reg + 4'd1;
                        if (idx_reg == 4'd15) begin
                            state_next  = OUT;
                            bfirst_next = first_reg;
                            blast_next  = 1'b0;
                        end
                    end else begin
                        state_next  = OUT;
                        bfirst_next = first_reg;
                        if (pos < 7'd64) begin
                            buf_next[pos[5:0]] = 8'h80;
                        end
                        // Length fits only if the 8 trailing bytes are still free.
                        if (pos <= 7'd55) begin
                            buf_next[56:63] = len_new;
                            blast_next      = 1'b1;
                        end else begin
                            blast_next = 1'b0;
                            extra_next = 1'b1;
                            mark_next  = (pos == 7'd64);
                        end
                    end
                end
            end
            OUT: begin
                if (blk_fire) begin
                    first_next = 1'b0;
                    if (extra_reg) begin
                        buf_next = '0;
                        if (mark_reg) begin
                            buf_next[0] = 8'h80;
                        end
                        buf_next[56:63] = len_cur;
                        bfirst_next     = 1'b0;
                        blast_next      = 1'b1;
                        extra_next      = 1'b0;
                        mark_next       = 1'b0;
                    end else begin
                        state_next = ACCUM;
                        buf_next   = '0;
                        idx_next   = '0;
                        if (blast_reg) begin
                            cnt_next   = '0;
                            first_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ACCUM);
        blk_valid = (state_reg == OUT);
        blk_first = (state_reg == OUT) & bfirst_reg;
        blk_last  = (state_reg == OUT) & blast_reg;
        blk_data  = buf_reg;
    end

endmodule
